// File: rtl/mux_rr_nxw.sv
`default_nettype none
// ============================================================================
// mux_rr_nxw : N-channel, W-bit registered multiplexer with valid/ready
//              handshakes, manual select or fair round-robin arbitration.
// Revision   : 1.0
// ============================================================================
module mux_rr_nxw #(
    parameter int W  = 4,
    parameter int N  = 8,
    parameter int SW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    din,
    input  logic [N-1:0]      din_valid,
    output logic [N-1:0]      din_ready,
    input  logic              mode,
    input  logic [SW-1:0]     sel,
    output logic [W-1:0]      dout,
    output logic [SW-1:0]     dout_ch,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam logic [SW:0]   c_num_ch  = (SW+1)'(N);
    localparam logic [SW-1:0] c_last_ch = SW'(N-1);

    logic [SW-1:0] r_ptr;
    logic [W-1:0]  r_dout;
    logic [SW-1:0] r_dout_ch;
    logic          r_dout_valid;

    logic          w_load_en;
    logic          w_grant_valid;
    logic [SW-1:0] w_grant;
    logic [SW:0]   w_idx;
    logic [W-1:0]  w_data;
    logic          w_xfer;
    logic [SW-1:0] w_ptr_next;

    assign w_load_en = !r_dout_valid || dout_ready;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = '0;
        w_idx         = '0;
        if (mode) begin
            // Scanning from the farthest offset down lets the nearest valid channel win.
            for (int k = N-1; k >= 0; k--) begin
                w_idx = {1'b0, r_ptr} + (SW+1)'(k);
                if (w_idx >= c_num_ch) begin
                    w_idx = w_idx - c_num_ch;
                end
                if (din_valid[w_idx[SW-1:0]]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = w_idx[SW-1:0];
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if ((sel == SW'(i)) && din_valid[i]) begin
                    w_grant_valid = 1'b1;
                    w_grant       = SW'(i);
                end
            end
        end
    end

    always_comb begin
        w_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == SW'(i)) begin
                w_data = din[i*W +: W];
            end
        end
    end

    always_comb begin
        din_ready = '0;
        for (int i = 0; i < N; i++) begin
            din_ready[i] = rst_n && w_load_en && w_grant_valid && (w_grant == SW'(i));
        end
    end

    assign w_xfer     = w_load_en && w_grant_valid;
    assign w_ptr_next = (w_grant == c_last_ch) ? '0 : w_grant + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr        <= '0;
            r_dout       <= '0;
            r_dout_ch    <= '0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_dout       <= w_data;
                r_dout_ch    <= w_grant;
                r_dout_valid <= 1'b1;
                if (mode) begin
                    r_ptr <= w_ptr_next;
                end
            end else if (dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_ch    = r_dout_ch;
    assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_nxw.sv
`default_nettype none
// ============================================================================
// tb_mux_rr_nxw : directed pins plus randomized traffic against a
//                 behavioural model of mux_rr_nxw.
// Revision      : 1.0
// ============================================================================
module tb_mux_rr_nxw;

    localparam int W  = 4;
    localparam int N  = 8;
    localparam int SW = 3;
    localparam logic [N*W-1:0] BASE = 32'h7654_3210;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N*W-1:0] din;
    logic [N-1:0]   din_valid;
    logic [N-1:0]   din_ready;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [W-1:0]   dout;
    logic [SW-1:0]  dout_ch;
    logic           dout_valid;
    logic           dout_ready;

    int n_vec = 0;
    int n_err = 0;

    // model state: what the output register must hold after the next edge
    bit m_init  = 1'b0;
    int m_ptr   = 0;
    int m_dout  = 0;
    int m_ch    = 0;
    bit m_valid = 1'b0;

    mux_rr_nxw #(.W(W), .N(N), .SW(SW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .mode       (mode),
        .sel        (sel),
        .dout       (dout),
        .dout_ch    (dout_ch),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Compare process: checks outputs every cycle, then advances the model.
    always @(negedge clk) begin
        int g;
        bit gv;
        bit load;
        logic [N-1:0] er;
        if (m_init) begin
            chk("m_dout", 32'(dout), 32'(m_dout));
            chk("m_dout_ch", 32'(dout_ch), 32'(m_ch));
            chk("m_dout_valid", 32'(dout_valid), 32'(m_valid));
        end
        gv = 1'b0;
        g  = 0;
        if (mode) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (!gv && din_valid[c]) begin
                    gv = 1'b1;
                    g  = c;
                end
            end
        end else if (int'(sel) < N && din_valid[sel]) begin
            gv = 1'b1;
            g  = int'(sel);
        end
        load = !m_valid || dout_ready;
        er   = '0;
        if (rst_n && load && gv) er[g] = 1'b1;
        if (m_init || !rst_n) chk("m_din_ready", 32'(din_ready), 32'(er));
        if (!rst_n) begin
            m_init  = 1'b1;
            m_ptr   = 0;
            m_dout  = 0;
            m_ch    = 0;
            m_valid = 1'b0;
        end else if (m_init) begin
            if (load && gv) begin
                m_dout  = int'(din[g*W +: W]);
                m_ch    = g;
                m_valid = 1'b1;
                if (mode) m_ptr = (g + 1) % N;
            end else if (dout_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    initial begin
        // reset with every channel valid
        rst_n = 1'b0; din = BASE; din_valid = '1; mode = 1'b1; sel = '0; dout_ready = 1'b1;
        cyc(); cyc();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_dout_ch", 32'(dout_ch), 32'h0);
        chk("rst_dout_valid", 32'(dout_valid), 32'h0);
        chk("rst_din_ready", 32'(din_ready), 32'h0);
        rst_n = 1'b1;
        #1 chk("rr_first_grant", 32'(din_ready), 32'h01);

        // round-robin fairness across all channels
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("fair_ch", 32'(dout_ch), 32'(k % 8));
            chk("fair_dout", 32'(dout), 32'(k % 8));
            chk("fair_valid", 32'(dout_valid), 32'h1);
        end

        // manual select of channel 5
        mode = 1'b0; sel = 3'd5; din = 32'h76A4_3210; din_valid = 8'h20;
        #1 chk("man_ready", 32'(din_ready), 32'h20);
        cyc();
        chk("man_dout", 32'(dout), 32'hA);
        chk("man_ch", 32'(dout_ch), 32'h5);
        chk("man_valid", 32'(dout_valid), 32'h1);

        // sparse round-robin from a freshly reset pointer
        rst_n = 1'b0; din = BASE; din_valid = 8'h84; mode = 1'b1;
        cyc();
        rst_n = 1'b1;
        #1 chk("sparse_ready0", 32'(din_ready), 32'h04);
        cyc();
        chk("sparse_ch2", 32'(dout_ch), 32'h2);
        #1 chk("sparse_ready1", 32'(din_ready), 32'h80);
        cyc();
        chk("sparse_ch7", 32'(dout_ch), 32'h7);
        #1 chk("sparse_ready2", 32'(din_ready), 32'h04);
        cyc();
        chk("sparse_ch2b", 32'(dout_ch), 32'h2);
        #1 chk("sparse_ready3", 32'(din_ready), 32'h80);

        // back-pressure with channel 1 waiting
        dout_ready = 1'b0; din_valid = 8'h02;
        #1 chk("bp_ready", 32'(din_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_dout", 32'(dout), 32'h2);
            chk("bp_ch", 32'(dout_ch), 32'h2);
            chk("bp_valid", 32'(dout_valid), 32'h1);
            chk("bp_ready_hold", 32'(din_ready), 32'h0);
        end
        dout_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(din_ready), 32'h02);
        cyc();
        chk("bp_refill_dout", 32'(dout), 32'h1);
        chk("bp_refill_ch", 32'(dout_ch), 32'h1);
        chk("bp_refill_valid", 32'(dout_valid), 32'h1);

        // manual select of an idle channel while others are valid
        mode = 1'b0; sel = 3'd3; din_valid = 8'hF7; dout_ready = 1'b0;
        #1 chk("idle_ready_bp", 32'(din_ready), 32'h0);
        dout_ready = 1'b1;
        #1 chk("idle_ready", 32'(din_ready), 32'h0);
        cyc();
        chk("idle_valid", 32'(dout_valid), 32'h0);
        chk("idle_dout", 32'(dout), 32'h1);
        chk("idle_ch", 32'(dout_ch), 32'h1);

        // reset while a word is held
        sel = 3'd4; din_valid = 8'h10;
        cyc();
        chk("held_valid", 32'(dout_valid), 32'h1);
        chk("held_dout", 32'(dout), 32'h4);
        dout_ready = 1'b0; rst_n = 1'b0;
        cyc();
        chk("rst_held_valid", 32'(dout_valid), 32'h0);
        chk("rst_held_dout", 32'(dout), 32'h0);
        rst_n = 1'b1;

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            cyc();
            rst_n      = ($urandom_range(0, 99) != 0);
            din        = $urandom;
            din_valid  = N'($urandom);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            sel        = SW'($urandom);
            dout_ready = ($urandom_range(0, 3) != 0);
        end
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
